// File: rtl/conv_vect_ser_q_if.sv
// Sample stream into, and requantised pixel stream out of, the serial conv vector unit.
interface conv_vect_ser_q_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 8
);
    logic                         valid_i;
    logic signed [DATA_WIDTH-1:0] data_i;
    logic                         sop_i;
    logic                         eop_i;
    logic                         sof_i;
    logic                         eof_i;
    logic signed [OUT_WIDTH-1:0]  data_o;
    logic                         data_valid_o;
    logic                         sop_o;
    logic                         eop_o;
    logic                         sof_o;
    logic                         eof_o;

    modport master (
        output valid_i, data_i, sop_i, eop_i, sof_i, eof_i,
        input  data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o
    );
    modport slave (
        input  valid_i, data_i, sop_i, eop_i, sof_i, eof_i,
        output data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o
    );
endinterface

// File: rtl/conv_vect_ser_q.sv
// Serial per-channel convolution vector unit: MAC over MTRX_NUM taps, bias, requantise, reframe.
// Kernel and bias ROM images are supplied as packed parameters, entry 0 in the low bits.
module conv_vect_ser_q #(
    parameter int DATA_WIDTH   = 8,
    parameter int KERNEL_WIDTH = 8,
    parameter int CHANNEL_NUM  = 3,
    parameter int MTRX_NUM     = 9,
    parameter int STRING_LEN   = 224,
    parameter int LINE_NUM     = 224,
    parameter int BIAS_WIDTH   = 24,
    parameter int OUT_WIDTH    = 8,
    parameter int SHIFT        = 7,
    parameter int RELU_EN      = 0,
    parameter logic [KERNEL_WIDTH*CHANNEL_NUM*MTRX_NUM-1:0] KERNEL_ROM = '0,
    parameter logic [BIAS_WIDTH*CHANNEL_NUM-1:0]            BIAS_ROM   = '0
) (
    input logic              clk,
    input logic              reset,
    conv_vect_ser_q_if.slave bus
);
    localparam int ACC_WIDTH = DATA_WIDTH + KERNEL_WIDTH + $clog2(MTRX_NUM) + 1;
    localparam int SUM_WIDTH = ((ACC_WIDTH > BIAS_WIDTH) ? ACC_WIDTH : BIAS_WIDTH) + 1;
    localparam int RND_WIDTH = SUM_WIDTH + 1;
    localparam int K_NUM     = CHANNEL_NUM * MTRX_NUM;
    localparam int CW  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int MW  = (MTRX_NUM > 1)    ? $clog2(MTRX_NUM)    : 1;
    localparam int KAW = (K_NUM > 1)       ? $clog2(K_NUM)       : 1;
    localparam int PW  = (STRING_LEN > 1)  ? $clog2(STRING_LEN)  : 1;
    localparam int LW  = (LINE_NUM > 1)    ? $clog2(LINE_NUM)    : 1;
    localparam logic signed [RND_WIDTH-1:0] RND =
        (SHIFT > 0) ? (RND_WIDTH'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [RND_WIDTH-1:0] O_MAX = RND_WIDTH'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [RND_WIDTH-1:0] O_MIN = ~O_MAX;

    logic [CW-1:0]  c_cnt, c_eff;
    logic [MW-1:0]  m_cnt, m_eff;
    logic [KAW-1:0] k_cnt, k_eff;

    // NOTE: every variable of this block is assigned on every path, so no latch is inferred.
    always_comb begin
        c_eff = bus.sof_i ? '0 : c_cnt;
        m_eff = bus.sof_i ? '0 : m_cnt;
        k_eff = bus.sof_i ? '0 : k_cnt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_cnt <= '0;
            m_cnt <= '0;
            k_cnt <= '0;
        end else if (bus.valid_i) begin
            k_cnt <= (k_eff == KAW'(K_NUM - 1)) ? '0 : k_eff + KAW'(1);
            c_cnt <= (c_eff == CW'(CHANNEL_NUM - 1)) ? '0 : c_eff + CW'(1);
            if (c_eff == CW'(CHANNEL_NUM - 1))
                m_cnt <= (m_eff == MW'(MTRX_NUM - 1)) ? '0 : m_eff + MW'(1);
            else
                m_cnt <= m_eff;
        end
    end

    logic                           v1, v2;
    logic [3:0]                     ov;       // output-bearing valids, stages 3..6
    logic [5:0]                     sf_pipe;  // sof marker travelling alongside samples
    logic [CW-1:0]                  c1, c2;
    logic                           first1, first2, last1, last2;
    logic signed [DATA_WIDTH-1:0]   data1;
    logic signed [KERNEL_WIDTH-1:0] kern1;
    logic signed [BIAS_WIDTH-1:0]   bias1, bias2;
    logic signed [ACC_WIDTH-1:0]    prod2, rd2, sum2;
    logic signed [SUM_WIDTH-1:0]    s3;
    logic signed [RND_WIDTH-1:0]    r4;
    logic signed [OUT_WIDTH-1:0]    sat5, relu6;
    logic signed [ACC_WIDTH-1:0]    acc_mem [CHANNEL_NUM];

    always_ff @(posedge clk) begin
        if (reset) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            ov      <= '0;
            sf_pipe <= '0;
        end else begin
            v1      <= bus.valid_i;
            v2      <= v1;
            ov      <= {ov[2:0], v2 && last2};
            sf_pipe <= {sf_pipe[4:0], bus.valid_i && bus.sof_i};
        end
    end

    // Same-channel back-to-back samples read before the previous write lands: forward it.
    assign sum2 = (first2 ? '0 : rd2) + prod2;

    always_ff @(posedge clk) begin
        c1     <= c_eff;
        first1 <= (m_eff == '0);
        last1  <= (m_eff == MW'(MTRX_NUM - 1));
        data1  <= bus.data_i;
        kern1  <= KERNEL_ROM[k_eff*KERNEL_WIDTH +: KERNEL_WIDTH];
        bias1  <= BIAS_ROM[c_eff*BIAS_WIDTH +: BIAS_WIDTH];
        c2     <= c1;
        first2 <= first1;
        last2  <= last1;
        bias2  <= bias1;
        prod2  <= ACC_WIDTH'(data1) * ACC_WIDTH'(kern1);
        rd2    <= (v2 && c2 == c1) ? sum2 : acc_mem[c1];
        s3     <= SUM_WIDTH'(sum2) + SUM_WIDTH'(bias2);
        r4     <= (RND_WIDTH'(s3) + RND) >>> SHIFT;
        sat5   <= (r4 > O_MAX) ? O_MAX[OUT_WIDTH-1:0] :
                  (r4 < O_MIN) ? O_MIN[OUT_WIDTH-1:0] : r4[OUT_WIDTH-1:0];
        relu6  <= (RELU_EN != 0 && sat5[OUT_WIDTH-1]) ? '0 : sat5;
    end

    // NOTE: the accumulator RAM is not reset; tap 0 always overwrites, so stale contents never leak.
    always_ff @(posedge clk) begin
        if (v2 && !reset)
            acc_mem[c2] <= sum2;
    end

    logic [CW-1:0] chan_cnt, chan_e;
    logic [PW-1:0] pix_cnt, pix_e;
    logic [LW-1:0] line_cnt, line_e;
    logic          at_sop, at_eop;

    always_comb begin
        chan_e = sf_pipe[5] ? '0 : chan_cnt;
        pix_e  = sf_pipe[5] ? '0 : pix_cnt;
        line_e = sf_pipe[5] ? '0 : line_cnt;
        at_sop = (chan_e == '0) && (pix_e == '0);
        at_eop = (chan_e == CW'(CHANNEL_NUM - 1)) && (pix_e == PW'(STRING_LEN - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data_o       <= '0;
            bus.data_valid_o <= 1'b0;
            bus.sop_o        <= 1'b0;
            bus.eop_o        <= 1'b0;
            bus.sof_o        <= 1'b0;
            bus.eof_o        <= 1'b0;
            chan_cnt         <= '0;
            pix_cnt          <= '0;
            line_cnt         <= '0;
        end else begin
            bus.data_valid_o <= ov[3];
            bus.sop_o        <= ov[3] && at_sop;
            bus.eop_o        <= ov[3] && at_eop;
            bus.sof_o        <= ov[3] && at_sop && (line_e == '0);
            bus.eof_o        <= ov[3] && at_eop && (line_e == LW'(LINE_NUM - 1));
            if (ov[3]) begin
                bus.data_o <= relu6;
                chan_cnt   <= (chan_e == CW'(CHANNEL_NUM - 1)) ? '0 : chan_e + CW'(1);
                pix_cnt    <= pix_e;
                line_cnt   <= line_e;
                if (chan_e == CW'(CHANNEL_NUM - 1)) begin
                    pix_cnt <= (pix_e == PW'(STRING_LEN - 1)) ? '0 : pix_e + PW'(1);
                    if (pix_e == PW'(STRING_LEN - 1))
                        line_cnt <= (line_e == LW'(LINE_NUM - 1)) ? '0 : line_e + LW'(1);
                end
            end else if (sf_pipe[5]) begin
                chan_cnt <= '0;
                pix_cnt  <= '0;
                line_cnt <= '0;
            end
        end
    end

    logic framing_in_unused;
    assign framing_in_unused = ^{bus.sop_i, bus.eop_i, bus.eof_i};
endmodule

// File: tb/tb_conv_vect_ser_q.sv
// Directed bench for conv_vect_ser_q: five configurations fed from one shared stimulus bus.
module tb_conv_vect_ser_q;
    typedef struct packed {
        logic [63:0] t;
        logic [3:0]  fr;    // {sof, sop, eop, eof}
        logic [31:0] val;
    } ev_t;

    logic              clk;
    logic              reset;
    logic              valid;
    logic              sof;
    logic signed [7:0] data;
    logic [4:0]        en;     // A, B, C, D, E
    time               acc_t;
    int                n_vec = 0;
    int                n_miss = 0;
    int                idle_frame_err = 0;
    int                na = 0;
    ev_t               qa[$], qb[$], qc[$], qd[$], qe[$];
    logic [3:0]        fr_exp [8] = '{4'b1100, 4'b0000, 4'b0000, 4'b0010,
                                      4'b0100, 4'b0000, 4'b0000, 4'b0011};

    conv_vect_ser_q_if #(.DATA_WIDTH(8), .OUT_WIDTH(16)) if_a ();
    conv_vect_ser_q_if #(.DATA_WIDTH(8), .OUT_WIDTH(16)) if_b ();
    conv_vect_ser_q_if #(.DATA_WIDTH(8), .OUT_WIDTH(8))  if_c ();
    conv_vect_ser_q_if #(.DATA_WIDTH(8), .OUT_WIDTH(8))  if_d ();
    conv_vect_ser_q_if #(.DATA_WIDTH(8), .OUT_WIDTH(8))  if_e ();

    assign {if_a.valid_i, if_a.data_i, if_a.sop_i, if_a.eop_i, if_a.sof_i, if_a.eof_i} = {valid && en[0], data, 1'b0, 1'b0, sof, 1'b0};
    assign {if_b.valid_i, if_b.data_i, if_b.sop_i, if_b.eop_i, if_b.sof_i, if_b.eof_i} = {valid && en[1], data, 1'b0, 1'b0, sof, 1'b0};
    assign {if_c.valid_i, if_c.data_i, if_c.sop_i, if_c.eop_i, if_c.sof_i, if_c.eof_i} = {valid && en[2], data, 1'b0, 1'b0, sof, 1'b0};
    assign {if_d.valid_i, if_d.data_i, if_d.sop_i, if_d.eop_i, if_d.sof_i, if_d.eof_i} = {valid && en[3], data, 1'b0, 1'b0, sof, 1'b0};
    assign {if_e.valid_i, if_e.data_i, if_e.sop_i, if_e.eop_i, if_e.sof_i, if_e.eof_i} = {valid && en[4], data, 1'b0, 1'b0, sof, 1'b0};

    conv_vect_ser_q #(.CHANNEL_NUM(2), .MTRX_NUM(3), .STRING_LEN(2), .LINE_NUM(2), .OUT_WIDTH(16),
        .SHIFT(0), .KERNEL_ROM({6{8'h01}}), .BIAS_ROM('0)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    conv_vect_ser_q #(.CHANNEL_NUM(1), .MTRX_NUM(4), .OUT_WIDTH(16), .SHIFT(0),
        .KERNEL_ROM({4{8'h03}}), .BIAS_ROM(24'd10)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
    conv_vect_ser_q #(.CHANNEL_NUM(1), .MTRX_NUM(9), .SHIFT(7), .RELU_EN(0),
        .KERNEL_ROM({9{8'h7f}}), .BIAS_ROM('0)) dut_c (.clk(clk), .reset(reset), .bus(if_c));
    conv_vect_ser_q #(.CHANNEL_NUM(1), .MTRX_NUM(9), .SHIFT(7), .RELU_EN(1),
        .KERNEL_ROM({9{8'h7f}}), .BIAS_ROM('0)) dut_d (.clk(clk), .reset(reset), .bus(if_d));
    conv_vect_ser_q #(.CHANNEL_NUM(1), .MTRX_NUM(9), .SHIFT(7), .RELU_EN(0),
        .KERNEL_ROM({9{8'h01}}), .BIAS_ROM('0)) dut_e (.clk(clk), .reset(reset), .bus(if_e));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ev_t mk(input logic [3:0] fr, input logic signed [31:0] v);
        ev_t e;
        e.t   = 64'($time);
        e.fr  = fr;
        e.val = v;
        return e;
    endfunction

    always @(negedge clk) begin
        if (if_a.data_valid_o) qa.push_back(mk({if_a.sof_o, if_a.sop_o, if_a.eop_o, if_a.eof_o}, if_a.data_o));
        else if (|{if_a.sof_o, if_a.sop_o, if_a.eop_o, if_a.eof_o}) idle_frame_err++;
        if (if_b.data_valid_o) qb.push_back(mk({if_b.sof_o, if_b.sop_o, if_b.eop_o, if_b.eof_o}, if_b.data_o));
        if (if_c.data_valid_o) qc.push_back(mk(4'b0, if_c.data_o));
        if (if_d.data_valid_o) qd.push_back(mk(4'b0, if_d.data_o));
        if (if_e.data_valid_o) qe.push_back(mk(4'b0, if_e.data_o));
    end

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int id, input int exp_val, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        case (id)
            0: if (qa.size() > 0) begin e = qa.pop_front(); ok = 1'b1; end
            1: if (qb.size() > 0) begin e = qb.pop_front(); ok = 1'b1; end
            2: if (qc.size() > 0) begin e = qc.pop_front(); ok = 1'b1; end
            3: if (qd.size() > 0) begin e = qd.pop_front(); ok = 1'b1; end
            default: if (qe.size() > 0) begin e = qe.pop_front(); ok = 1'b1; end
        endcase
        check({tag, "_present"}, 64'(ok), 1);
        if (ok) check(tag, $signed(e.val), exp_val);
    endtask

    task automatic send(input logic signed [7:0] d, input logic s, input int gap);
        valid = 1'b1;
        data  = d;
        sof   = s;
        @(posedge clk);
        acc_t = $time;
        #1;
        valid = 1'b0;
        sof   = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Config A group: data 1..6 -> ch0 = 1+3+5 = 9, ch1 = 2+4+6 = 12, each 6 cycles after its last tap.
    task automatic a_group(input string tag, input int maxgap, input logic first_sof);
        ev_t e;
        bit  ok;
        time t5 = 0, t6 = 0;
        for (int i = 1; i <= 6; i++) begin
            send(8'(i), (i == 1) ? first_sof : 1'b0, (i == 6) ? 0 : int'($urandom_range(0, maxgap)));
            if (i == 5) t5 = acc_t;
            if (i == 6) t6 = acc_t;
        end
        settle();
        expect_out({tag, "_c0"}, 0, 9, e, ok);
        if (ok) begin
            check({tag, "_c0_lat"}, 64'(e.t - 64'(t5)), 65);
            check({tag, "_c0_frame"}, 64'(e.fr), 64'(fr_exp[na % 8]));
        end
        na++;
        expect_out({tag, "_c1"}, 0, 12, e, ok);
        if (ok) begin
            check({tag, "_c1_lat"}, 64'(e.t - 64'(t6)), 65);
            check({tag, "_c1_frame"}, 64'(e.fr), 64'(fr_exp[na % 8]));
        end
        na++;
        check({tag, "_extra"}, qa.size(), 0);
    endtask

    task automatic cde_group(input string tag, input logic signed [7:0] d0, input logic signed [7:0] d1,
                             input logic signed [7:0] rest, input int ec, input int ed, input int ee);
        ev_t e;
        bit  ok;
        send(d0, 1'b0, 0);
        send(d1, 1'b0, 0);
        for (int i = 0; i < 7; i++) send(rest, 1'b0, 0);
        settle();
        expect_out({tag, "_sat"}, 2, ec, e, ok);
        expect_out({tag, "_relu"}, 3, ed, e, ok);
        expect_out({tag, "_rnd"}, 4, ee, e, ok);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ev_t e;
        bit  ok;
        reset = 1'b1;
        valid = 1'b0;
        sof   = 1'b0;
        data  = '0;
        en    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(if_a.data_valid_o), 0);
        check("rst_data", if_a.data_o, 0);
        check("rst_frame", 64'({if_a.sof_o, if_a.sop_o, if_a.eop_o, if_a.eof_o}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Config A: back-to-back, gapped, then back-to-back again (framing wraps on #9).
        en = 5'b00001;
        a_group("a_b2b", 0, 1'b0);
        for (int g = 0; g < 3; g++) a_group("a_gap", 3, 1'b0);
        a_group("a_wrap", 0, 1'b0);

        // Reset two cycles after a last-tap sample, with the next group already started.
        for (int i = 1; i <= 6; i++) send(8'(i), 1'b0, 0);
        send(8'sd50, 1'b0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        settle();
        check("a_rst_mid_none", qa.size(), 0);
        na = 0;
        a_group("a_post_rst", 0, 1'b0);

        // sof mid-group: partial sums of 100 must be discarded and framing restarts.
        for (int i = 0; i < 3; i++) send(8'sd100, 1'b0, 0);
        na = 0;
        a_group("a_sof", 0, 1'b1);
        check("a_idle_frame", idle_frame_err, 0);

        // Config B: single channel, forwarding path; 4 taps * 3 * (1..4) + 10 = 40.
        en = 5'b00010;
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, (r == 2) ? 2 : 0);
            settle();
            expect_out((r == 2) ? "b_gap" : "b_fwd", 1, 40, e, ok);
            if (r == 0 && ok) check("b_frame", 64'(e.fr), 64'(4'b1100));
        end
        check("b_extra", qb.size(), 0);

        // Configs C (sat), D (ReLU), E (kernel 1, rounding), driven together.
        en = 5'b11100;
        cde_group("pos",  8'sd127,  8'sd127,  8'sd127,  127, 127,  9);
        cde_group("neg", -8'sd128, -8'sd128, -8'sd128, -128,   0, -9);
        cde_group("s192", 8'sd127,  8'sd65,   8'sd0,    127, 127,  2);
        cde_group("s191", 8'sd127,  8'sd64,   8'sd0,    127, 127,  1);
        check("cde_extra", qc.size() + qd.size() + qe.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
